// File: rtl/label_frame_writer_if.sv
// rtl/label_frame_writer_if.sv - label stream input and label RAM write port bundle
interface label_frame_writer_if #(
    parameter int ADDR_W  = 17,
    parameter int LABEL_W = 3
);
    logic               in_valid;
    logic               in_sof;
    logic [LABEL_W-1:0] in_label;
    logic               in_ready;
    logic               we;
    logic [ADDR_W-1:0]  w_addr;
    logic [LABEL_W-1:0] write_data;

    // Label source side: drives beats, observes the RAM write port
    modport master (
        output in_valid, in_sof, in_label,
        input  in_ready, we, w_addr, write_data
    );

    // Frame writer side: consumes beats, drives the RAM write port
    modport slave (
        input  in_valid, in_sof, in_label,
        output in_ready, we, w_addr, write_data
    );
endinterface

// File: rtl/label_frame_writer.sv
// rtl/label_frame_writer.sv - label stream to linear label RAM writes with clear sweep
module label_frame_writer #(
    parameter int H_RES       = 320,
    parameter int V_RES       = 240,
    parameter int ADDR_W      = 17,
    parameter int LABEL_W     = 3,
    parameter int CLEAR_LABEL = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear_req,
    label_frame_writer_if.slave  bus,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 frame_err
);
    localparam logic [ADDR_W-1:0]  LAST  = ADDR_W'(H_RES * V_RES - 1);
    localparam logic [ADDR_W-1:0]  NPIX  = ADDR_W'(H_RES * V_RES);
    localparam logic [LABEL_W-1:0] CLR_V = LABEL_W'(CLEAR_LABEL);

    typedef enum logic [1:0] {IDLE, WAIT_SOF, WRITE, CLEAR} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LABEL_W-1:0]  data_q, data_d;
    logic                we_q, we_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                last_q, last_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                accept;

    // A clear request masks ready in the same cycle so no beat slips in ahead of the sweep
    assign bus.in_ready   = ready_q & ~clear_req;
    assign accept         = bus.in_valid & bus.in_ready;
    assign bus.we         = we_q;
    assign bus.w_addr     = addr_q;
    assign bus.write_data = data_q;
    assign busy           = busy_q;
    assign frame_done     = done_q;
    assign frame_err      = err_q;

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            last_q  <= last_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next state and next output values; frame_done trails the LAST write by one cycle via last_q
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = 1'b0;
        busy_d  = 1'b0;
        last_d  = 1'b0;
        done_d  = last_q;
        err_d   = 1'b0;
        if (clear_req) begin
            state_d = CLEAR;
            cnt_d   = ADDR_W'(1);
            we_d    = 1'b1;
            addr_d  = '0;
            data_d  = CLR_V;
            busy_d  = 1'b1;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: state_d = WAIT_SOF;
                WAIT_SOF: begin
                    if (accept && bus.in_sof) begin
                        we_d    = 1'b1;
                        addr_d  = '0;
                        data_d  = bus.in_label;
                        cnt_d   = ADDR_W'(1);
                        state_d = WRITE;
                    end
                end
                WRITE: begin
                    if (accept) begin
                        we_d   = 1'b1;
                        data_d = bus.in_label;
                        if (bus.in_sof) begin
                            addr_d = '0;
                            cnt_d  = ADDR_W'(1);
                            err_d  = 1'b1;
                        end else begin
                            addr_d = cnt_q;
                            if (cnt_q == LAST) begin
                                cnt_d   = '0;
                                last_d  = 1'b1;
                                state_d = WAIT_SOF;
                            end else begin
                                cnt_d = cnt_q + ADDR_W'(1);
                            end
                        end
                    end
                end
                CLEAR: begin
                    // cnt_q holds the next sweep address; reaching NPIX means LAST is already out
                    if (cnt_q == NPIX) begin
                        cnt_d   = '0;
                        state_d = WAIT_SOF;
                    end else begin
                        we_d   = 1'b1;
                        addr_d = cnt_q;
                        data_d = CLR_V;
                        busy_d = 1'b1;
                        cnt_d  = cnt_q + ADDR_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        ready_d = (state_d == WAIT_SOF) || (state_d == WRITE);
    end
endmodule

// File: tb/tb_label_frame_writer.sv
// tb/tb_label_frame_writer.sv - directed self-checking bench for label_frame_writer
module tb_label_frame_writer;
    localparam int H    = 40;
    localparam int V    = 30;
    localparam int NPIX = 1200;

    logic clk;
    logic reset;
    logic clear_req;
    logic busy;
    logic frame_done;
    logic frame_err;
    int   checks;
    int   failures;
    int   bad;

    label_frame_writer_if #(.ADDR_W(17), .LABEL_W(3)) bus ();

    label_frame_writer #(
        .H_RES(H), .V_RES(V), .ADDR_W(17), .LABEL_W(3), .CLEAR_LABEL(0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clear_req  (clear_req),
        .bus        (bus),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic sof, input logic [2:0] lbl);
        bus.in_valid = 1'b1;
        bus.in_sof   = sof;
        bus.in_label = lbl;
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        reset        = 1'b1;
        clear_req    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_label = 3'd0;
        tick;
        tick;

        // Reset state
        check("rst_we", 32'(bus.we), 32'd0);
        check("rst_addr", 32'(bus.w_addr), 32'd0);
        check("rst_data", 32'(bus.write_data), 32'd0);
        check("rst_ready", 32'(bus.in_ready), 32'd0);
        check("rst_busy_done_err", {29'd0, busy, frame_done, frame_err}, 32'd0);

        // 1: release, beats without sof are dropped
        reset = 1'b0;
        tick;
        check("t1_ready", 32'(bus.in_ready), 32'd1);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            beat(1'b0, 3'(i));
            tick;
            if (bus.we !== 1'b0 || bus.in_ready !== 1'b1) bad++;
        end
        check("t1_no_write", 32'(bad), 32'd0);

        // 2: full frame, labels i%8
        bad = 0;
        for (int i = 0; i < NPIX; i++) begin
            if (bus.in_ready !== 1'b1) bad++;
            beat(i == 0, 3'(i % 8));
            tick;
            if (bus.we !== 1'b1 || bus.w_addr !== 17'(i) || bus.write_data !== 3'(i % 8)
                || frame_done !== 1'b0 || frame_err !== 1'b0) bad++;
        end
        check("t2_frame_writes", 32'(bad), 32'd0);
        check("t2_last_addr", 32'(bus.w_addr), 32'(NPIX - 1));
        bus.in_valid = 1'b0;
        tick;
        check("t2_frame_done", 32'(frame_done), 32'd1);
        check("t2_we_idle", 32'(bus.we), 32'd0);
        // beats past LAST without sof are dropped
        beat(1'b0, 3'd7);
        tick;
        check("t2_done_pulse", 32'(frame_done), 32'd0);
        check("t2_no_wrap", 32'(bus.we), 32'd0);
        check("t2_addr_hold", 32'(bus.w_addr), 32'(NPIX - 1));
        bus.in_valid = 1'b0;
        tick;

        // 3: sof re-asserted at beat 1000
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            beat(i == 0, 3'(i % 8));
            tick;
            if (bus.we !== 1'b1 || bus.w_addr !== 17'(i) || frame_err !== 1'b0) bad++;
        end
        check("t3_pre_writes", 32'(bad), 32'd0);
        beat(1'b1, 3'd5);
        tick;
        check("t3_err", 32'(frame_err), 32'd1);
        check("t3_restart_addr", 32'(bus.w_addr), 32'd0);
        check("t3_restart_data", 32'(bus.write_data), 32'd5);
        beat(1'b0, 3'd6);
        tick;
        check("t3_err_pulse", 32'(frame_err), 32'd0);
        check("t3_next_addr", 32'(bus.w_addr), 32'd1);
        check("t3_next_data", 32'(bus.write_data), 32'd6);
        for (int i = 2; i <= 500; i++) begin
            beat(1'b0, 3'(i % 8));
            tick;
        end
        check("t3_at_500", 32'(bus.w_addr), 32'd500);

        // 4: clear mid-frame
        bus.in_valid = 1'b0;
        clear_req    = 1'b1;
        tick;
        clear_req = 1'b0;
        bad = 0;
        for (int i = 0; i < NPIX; i++) begin
            if (busy !== 1'b1 || bus.we !== 1'b1 || bus.w_addr !== 17'(i) || bus.write_data !== 3'd0
                || frame_done !== 1'b0 || bus.in_ready !== 1'b0) bad++;
            tick;
        end
        check("t4_sweep", 32'(bad), 32'd0);
        check("t4_busy_end", 32'(busy), 32'd0);
        check("t4_we_end", 32'(bus.we), 32'd0);
        check("t4_ready_back", 32'(bus.in_ready), 32'd1);
        check("t4_no_done", 32'(frame_done), 32'd0);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            beat(i == 0, 3'(i + 3));
            tick;
            if (bus.we !== 1'b1 || bus.w_addr !== 17'(i) || bus.write_data !== 3'(i + 3)) bad++;
        end
        check("t4_new_frame", 32'(bad), 32'd0);

        // 5: clear_req same cycle as an sof beat
        beat(1'b1, 3'd7);
        clear_req = 1'b1;
        #1;
        check("t5_ready_masked", 32'(bus.in_ready), 32'd0);
        tick;
        clear_req    = 1'b0;
        bus.in_valid = 1'b0;
        check("t5_sweep_addr0", 32'(bus.w_addr), 32'd0);
        check("t5_sweep_data", 32'(bus.write_data), 32'd0);
        check("t5_sweep_busy", {30'd0, busy, bus.we}, 32'd3);
        check("t5_no_err", 32'(frame_err), 32'd0);

        // 6: async reset mid-sweep at addr 300
        for (int i = 1; i <= 300; i++) tick;
        check("t6_at_300", 32'(bus.w_addr), 32'd300);
        reset = 1'b1;
        #1;
        check("t6_we", 32'(bus.we), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_addr", 32'(bus.w_addr), 32'd0);
        check("t6_ready", 32'(bus.in_ready), 32'd0);
        tick;
        reset = 1'b0;
        tick;
        check("t6_resume_ready", 32'(bus.in_ready), 32'd1);
        check("t6_resume_busy", 32'(busy), 32'd0);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            beat(1'b0, 3'd2);
            tick;
            if (bus.we !== 1'b0) bad++;
        end
        check("t6_wait_sof", 32'(bad), 32'd0);
        bus.in_valid = 1'b0;
        tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
